// File: rtl/reflet_arb_pkg.sv
// Shared definitions for the Reflet two-master bus arbiter: state encoding,
// one-hot owner codes, debug view and the counter-width helper.
package reflet_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_t;

  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_M0   = 2'b01;
  localparam logic [1:0] OWNER_M1   = 2'b10;

  // last: 0 = master 0 was granted most recently, 1 = master 1.
  typedef struct packed {
    arb_state_t state;
    logic       last;
  } arb_dbg_t;

  // Never returns 0 so a disabled hold limit still yields a legal vector width.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/reflet_arb_hold_counter.sv
// Anti-starvation hold counter: counts cycles the waiting master has been
// kept off the bus and flags when the owner must hand over.
module reflet_arb_hold_counter
  import reflet_arb_pkg::*;
#(
  parameter int max_hold = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic limit
);

  localparam int cw = clog2(max_hold + 1);
  localparam logic [cw-1:0] sat_val = cw'(max_hold);
  localparam logic [cw-1:0] lim_val = cw'((max_hold > 0) ? max_hold - 1 : 0);

  logic [cw-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (inc && (count != sat_val)) begin
      count <= count + cw'(1);
    end
  end

  // A limit of zero disables preemption entirely.
  assign limit = (max_hold != 0) && (count == lim_val);

endmodule

// File: rtl/reflet_bus_arbiter8.sv
// Two-master arbiter for the 8-bit Reflet bus: grant FSM, hold-limit
// preemption, bus mux and read-data return routing.
// Tie-break is fixed priority to master 0 unless REFLET_ARB_ROUND_ROBIN_EN is defined.
// Handshake: a master holds req high for its whole ownership and drives the
// bus only in cycles where its registered gnt is high; dropping req releases.
module reflet_bus_arbiter8
  import reflet_arb_pkg::*;
#(
  parameter int wordsize = 8,
  parameter int max_hold = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_req,
  output logic                m0_gnt,
  input  logic [wordsize-1:0] m0_addr,
  input  logic [wordsize-1:0] m0_data_out,
  input  logic                m0_write_en,
  output logic [wordsize-1:0] m0_data_in,
  input  logic                m1_req,
  output logic                m1_gnt,
  input  logic [wordsize-1:0] m1_addr,
  input  logic [wordsize-1:0] m1_data_out,
  input  logic                m1_write_en,
  output logic [wordsize-1:0] m1_data_in,
  output logic [wordsize-1:0] bus_addr,
  output logic [wordsize-1:0] bus_data_out,
  output logic                bus_write_en,
  input  logic [wordsize-1:0] bus_data_in,
  output logic [1:0]          owner,
  output arb_dbg_t            dbg
);

  arb_state_t cur_state, next_state, tie_pick;
  logic       last;
  logic [1:0] prev_owner;
  logic       other_req;
  logic       hold_limit;
  logic       hold_clear;

`ifdef REFLET_ARB_ROUND_ROBIN_EN
  assign tie_pick = last ? ST_OWN0 : ST_OWN1;
`else
  assign tie_pick = ST_OWN0;
`endif

  always_comb begin
    other_req = 1'b0;
    case (cur_state)
      ST_OWN0: other_req = m1_req;
      ST_OWN1: other_req = m0_req;
      default: other_req = 1'b0;
    endcase
  end

  always_comb begin
    next_state = cur_state;
    case (cur_state)
      ST_IDLE: begin
        if (m0_req && m1_req) next_state = tie_pick;
        else if (m0_req)      next_state = ST_OWN0;
        else if (m1_req)      next_state = ST_OWN1;
      end
      ST_OWN0: begin
        if (!m0_req)                 next_state = m1_req ? ST_OWN1 : ST_IDLE;
        else if (m1_req && hold_limit) next_state = ST_OWN1;
      end
      ST_OWN1: begin
        if (!m1_req)                 next_state = m0_req ? ST_OWN0 : ST_IDLE;
        else if (m0_req && hold_limit) next_state = ST_OWN0;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  assign hold_clear = (next_state != cur_state) || !other_req;

  reflet_arb_hold_counter #(.max_hold(max_hold)) u_hold (
    .clk   (clk),
    .reset (reset),
    .clear (hold_clear),
    .inc   (other_req),
    .limit (hold_limit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state  <= ST_IDLE;
      last       <= 1'b1;
      prev_owner <= OWNER_NONE;
    end else begin
      cur_state  <= next_state;
      prev_owner <= owner;
      if (next_state != cur_state) begin
        if (next_state == ST_OWN0) last <= 1'b0;
        if (next_state == ST_OWN1) last <= 1'b1;
      end
    end
  end

  always_comb begin
    owner = OWNER_NONE;
    case (cur_state)
      ST_OWN0: owner = OWNER_M0;
      ST_OWN1: owner = OWNER_M1;
      default: owner = OWNER_NONE;
    endcase
  end

  assign m0_gnt = owner[0];
  assign m1_gnt = owner[1];

  // Only the granted master reaches the bus; a non-owner strobe is dropped.
  always_comb begin
    bus_addr     = '0;
    bus_data_out = '0;
    bus_write_en = 1'b0;
    case (cur_state)
      ST_OWN0: begin
        bus_addr     = m0_addr;
        bus_data_out = m0_data_out;
        bus_write_en = m0_write_en & m0_gnt;
      end
      ST_OWN1: begin
        bus_addr     = m1_addr;
        bus_data_out = m1_data_out;
        bus_write_en = m1_write_en & m1_gnt;
      end
      default: ;
    endcase
  end

  // Slaves answer one cycle late, so return data follows last cycle's owner.
  assign m0_data_in = prev_owner[0] ? bus_data_in : '0;
  assign m1_data_in = prev_owner[1] ? bus_data_in : '0;

  assign dbg = '{state: cur_state, last: last};

endmodule

// File: tb/tb_reflet_bus_arbiter8.sv
// Directed bench for reflet_bus_arbiter8: vector table plus hand-written
// preemption and mid-ownership reset sequences.
module tb_reflet_bus_arbiter8;
  import reflet_arb_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       m0_req, m1_req, m0_gnt, m1_gnt;
  logic [7:0] m0_addr, m1_addr, m0_data_out, m1_data_out, m0_data_in, m1_data_in;
  logic       m0_write_en, m1_write_en;
  logic [7:0] bus_addr, bus_data_out, bus_data_in;
  logic       bus_write_en;
  logic [1:0] owner;
  arb_dbg_t   dbg;

  int errors = 0;
  int checks = 0;

  reflet_bus_arbiter8 #(.wordsize(8), .max_hold(16)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_gnt(m0_gnt), .m0_addr(m0_addr), .m0_data_out(m0_data_out),
    .m0_write_en(m0_write_en), .m0_data_in(m0_data_in),
    .m1_req(m1_req), .m1_gnt(m1_gnt), .m1_addr(m1_addr), .m1_data_out(m1_data_out),
    .m1_write_en(m1_write_en), .m1_data_in(m1_data_in),
    .bus_addr(bus_addr), .bus_data_out(bus_data_out), .bus_write_en(bus_write_en),
    .bus_data_in(bus_data_in), .owner(owner), .dbg(dbg)
  );

  // clock
  always #5 clk = ~clk;

  // Bus RAM model: records every write that actually lands on the bus.
  logic [7:0] ram [256];
  int wr_cnt = 0;
  always @(posedge clk) begin
    if (bus_write_en) begin
      ram[bus_addr] <= bus_data_out;
      wr_cnt <= wr_cnt + 1;
    end
  end

  typedef struct {
    logic       req0, req1;
    logic [7:0] a0, a1, wd0, wd1;
    logic       we0, we1;
    logic [7:0] bdin;
    logic       g0, g1;
    logic [1:0] own;
    logic [7:0] baddr, bdo;
    logic       bwe;
    logic [7:0] d0, d1;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_vec(input vec_t v);
    m0_req = v.req0; m1_req = v.req1;
    m0_addr = v.a0; m1_addr = v.a1;
    m0_data_out = v.wd0; m1_data_out = v.wd1;
    m0_write_en = v.we0; m1_write_en = v.we1;
    bus_data_in = v.bdin;
  endtask

  int n;
  int wr_snap;

  initial begin
    //          r0 r1  a0     a1     wd0    wd1    w0 w1 bdin  | g0 g1 own    baddr  bdo    bwe d0     d1
    vecs[0]  = '{0, 1, 8'h12, 8'h85, 8'h34, 8'hA7, 0, 0, 8'h11, 0, 1, 2'b10, 8'h85, 8'hA7, 0, 8'h00, 8'h00};
    vecs[1]  = '{0, 1, 8'h12, 8'h85, 8'h34, 8'hA7, 0, 1, 8'h22, 0, 1, 2'b10, 8'h85, 8'hA7, 1, 8'h00, 8'h22};
    vecs[2]  = '{0, 0, 8'h12, 8'h85, 8'h34, 8'hA7, 0, 0, 8'h33, 0, 0, 2'b00, 8'h00, 8'h00, 0, 8'h00, 8'h33};
    vecs[3]  = '{0, 0, 8'h12, 8'h85, 8'h34, 8'hA7, 0, 0, 8'h44, 0, 0, 2'b00, 8'h00, 8'h00, 0, 8'h00, 8'h00};
    vecs[4]  = '{1, 1, 8'h12, 8'h85, 8'h34, 8'hA7, 0, 0, 8'h55, 1, 0, 2'b01, 8'h12, 8'h34, 0, 8'h00, 8'h00};
    vecs[5]  = '{0, 0, 8'h12, 8'h85, 8'h34, 8'hA7, 0, 0, 8'h66, 0, 0, 2'b00, 8'h00, 8'h00, 0, 8'h66, 8'h00};
`ifdef REFLET_ARB_ROUND_ROBIN_EN
    vecs[6]  = '{1, 1, 8'h12, 8'h85, 8'h34, 8'hA7, 0, 0, 8'h00, 0, 1, 2'b10, 8'h85, 8'hA7, 0, 8'h00, 8'h00};
`else
    vecs[6]  = '{1, 1, 8'h12, 8'h85, 8'h34, 8'hA7, 0, 0, 8'h00, 1, 0, 2'b01, 8'h12, 8'h34, 0, 8'h00, 8'h00};
`endif
    vecs[7]  = '{0, 0, 8'h12, 8'h85, 8'h34, 8'hA7, 0, 0, 8'h00, 0, 0, 2'b00, 8'h00, 8'h00, 0, 8'h00, 8'h00};
    vecs[8]  = '{1, 0, 8'h12, 8'h85, 8'h34, 8'hA7, 1, 0, 8'h00, 1, 0, 2'b01, 8'h12, 8'h34, 1, 8'h00, 8'h00};
    vecs[9]  = '{1, 1, 8'h80, 8'h85, 8'h34, 8'hFF, 0, 1, 8'h77, 1, 0, 2'b01, 8'h80, 8'h34, 0, 8'h77, 8'h00};
    vecs[10] = '{0, 1, 8'h80, 8'h85, 8'h34, 8'hFF, 0, 0, 8'h5A, 0, 1, 2'b10, 8'h85, 8'hFF, 0, 8'h5A, 8'h00};
    vecs[11] = '{0, 0, 8'h80, 8'h85, 8'h34, 8'hFF, 0, 0, 8'h99, 0, 0, 2'b00, 8'h00, 8'h00, 0, 8'h00, 8'h99};

    // reset state
    reset = 1'b1;
    m0_req = 0; m1_req = 0; m0_write_en = 0; m1_write_en = 0;
    m0_addr = 8'h12; m1_addr = 8'h85; m0_data_out = 8'h34; m1_data_out = 8'hA7;
    bus_data_in = 8'h3C;
    repeat (2) step();
    check("rst_m0_gnt", m0_gnt, 0);
    check("rst_m1_gnt", m1_gnt, 0);
    check("rst_owner", owner, 2'b00);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_bus_data_out", bus_data_out, 0);
    check("rst_bus_write_en", bus_write_en, 0);
    check("rst_m0_data_in", m0_data_in, 0);
    check("rst_m1_data_in", m1_data_in, 0);
    check("rst_state", dbg.state, ST_IDLE);
    check("rst_last", dbg.last, 1);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      apply_vec(vecs[i]);
      step();
      check($sformatf("v%0d_m0_gnt", i), m0_gnt, vecs[i].g0);
      check($sformatf("v%0d_m1_gnt", i), m1_gnt, vecs[i].g1);
      check($sformatf("v%0d_owner", i), owner, vecs[i].own);
      check($sformatf("v%0d_bus_addr", i), bus_addr, vecs[i].baddr);
      check($sformatf("v%0d_bus_data_out", i), bus_data_out, vecs[i].bdo);
      check($sformatf("v%0d_bus_write_en", i), bus_write_en, vecs[i].bwe);
      check($sformatf("v%0d_m0_data_in", i), m0_data_in, vecs[i].d0);
      check($sformatf("v%0d_m1_data_in", i), m1_data_in, vecs[i].d1);
    end
    // only the owned write of vector 1 may have reached the RAM
    check("ram_write_count", wr_cnt, 1);
    check("ram_85_unchanged", ram[8'h85], 8'hA7);

    // hold-limit preemption: m1 waits exactly max_hold cycles
    m0_write_en = 0; m1_write_en = 0; bus_data_in = 8'h00;
    m0_req = 1; m1_req = 0;
    step();
    check("pre_m0_gnt", m0_gnt, 1);
    m1_req = 1;
    n = 0;
    while (!m1_gnt && n < 40) begin
      step();
      n++;
    end
    check("preempt_latency", n, 16);
    check("preempt_m0_drop", m0_gnt, 0);
    n = 0;
    while (!m0_gnt && n < 40) begin
      step();
      n++;
    end
    check("regain_latency", n, 16);
    check("regain_m1_drop", m1_gnt, 0);

    // reset while master 1 owns the bus with a write strobe high
    m0_req = 0; m1_req = 1; m1_write_en = 1; m1_data_out = 8'hC3;
    step();
    check("own1_m1_gnt", m1_gnt, 1);
    check("own1_bus_write_en", bus_write_en, 1);
    reset = 1'b1;
    step();
    check("mrst_m0_gnt", m0_gnt, 0);
    check("mrst_m1_gnt", m1_gnt, 0);
    check("mrst_owner", owner, 2'b00);
    check("mrst_bus_write_en", bus_write_en, 0);
    check("mrst_state", dbg.state, ST_IDLE);
    wr_snap = wr_cnt;
    step();
    check("mrst_no_write", wr_cnt, wr_snap);
    check("mrst_bus_write_en_hold", bus_write_en, 0);
    reset = 1'b0; m1_req = 0; m1_write_en = 0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reflet_bus_arbiter8.md
# reflet_bus_arbiter8

Two-master arbiter for the 8-bit Reflet system bus. Shares the single memory/peripheral bus (instruction RAM, data RAM, peripheral block) between the CPU (master 0) and a second master such as a DMA or UART program loader (master 1). Owns request/grant sequencing, a hold-limit anti-starvation counter, the bus multiplexer and read-data return routing.

## Interface
- `wordsize`, 8: data and address width.
- `max_hold`, 16: maximum consecutive cycles an owner keeps the bus while the other master waits; 0 disables the limit.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `m0_req` in 1: master 0 requests the bus; held high for the whole ownership.
- `m0_gnt` out 1: master 0 owns the bus (registered).
- `m0_addr` in wordsize: master 0 address.
- `m0_data_out` in wordsize: master 0 write data.
- `m0_write_en` in 1: master 0 write strobe.
- `m0_data_in` out wordsize: read data returned to master 0.
- `m1_req`, `m1_gnt`, `m1_addr`, `m1_data_out`, `m1_write_en`, `m1_data_in`: same as master 0, for master 1.
- `bus_addr` out wordsize: shared bus address.
- `bus_data_out` out wordsize: shared bus write data.
- `bus_write_en` out 1: shared bus write strobe.
- `bus_data_in` in wordsize: OR-combined read data from all slaves.
- `owner` out 2: one-hot current owner, {m1, m0}; 00 = idle.

## Operation
- States: IDLE, OWN0, OWN1. Reset: IDLE, both gnt 0, `owner` 00, hold counter 0, `last` = 1 (master 0 wins first tie), all bus outputs 0, both `mX_data_in` 0.
- IDLE: one request → grant that master next cycle. Both requesting → tie rule (see Configuration).
- OWNx, owner keeps req: stay. Owner drops req: other requesting → OWN(other) next cycle (direct handoff, no idle cycle); otherwise IDLE.
- Hold counter: increments each cycle in OWNx while the other master requests; clears on any state change or when the other's req is low. Reaching `max_hold`-1 with the other still requesting → forced handoff to the other master next cycle (preemption). A preempted master keeps req high and regains the bus by normal rules.
- `last` updates to the granted master on every transition into OWNx.
- Bus mux: `bus_addr`, `bus_data_out` = owner's signals; `bus_write_en` = owner's write_en AND its gnt. IDLE: all 0. Non-owner write_en never reaches the bus.
- Read return: slaves answer one cycle after address. Registered `prev_owner` = owner of previous cycle; `bus_data_in` routed to that master's `data_in`, other master's `data_in` = 0. In the first cycle after a handoff, the old owner still receives its final read datum.
- Reset mid-ownership: gnt drops in the reset cycle's next edge; no bus write emitted after reset is sampled.

## Timing
- req rise in IDLE → gnt high at next rising edge (1-cycle latency).
- req fall in OWNx → gnt low at next edge; handoff grant to other in the same edge.
- Masters drive the bus in cycles where their gnt is high; bus outputs are combinational from the state register, no extra latency.
- Read data valid at `mX_data_in` one cycle after the address cycle.
- Counter width: clog2(max_hold+1); saturates, never wraps.

## Configuration
- `REFLET_ARB_ROUND_ROBIN_EN` defined: simultaneous requests from IDLE grant the master not equal to `last`.
- Undefined: fixed priority, master 0 always wins ties; `last` still tracked but unused. Hold-limit preemption is active in both builds.

## Structure
- Shared package `reflet_arb_pkg`: state encoding (IDLE, OWN0, OWN1), one-hot owner constants, clog2 helper for counter width.
- One sub-module: `reflet_arb_hold_counter` (clear, increment, saturate, limit-reached flag, `max_hold`=0 bypass).

## Test plan
- Reset, then m1_req=1 only → m1_gnt=1 after 1 cycle, `owner`=10, bus_addr follows m1_addr=0x85.
- Both req from IDLE after reset → m0 granted; in round-robin build, repeat after release → m1 granted; fixed build → m0 again.
- m0 owns, m1 requests continuously, max_hold=16 → m0_gnt drops and m1_gnt rises exactly 16 cycles after m1_req rose.
- m0 reads 0x80 last cycle before handoff, slave returns 0x5A → m0_data_in=0x5A, m1_data_in=0 in handoff cycle.
- m1 (not owner) asserts write_en=1 with data 0xFF → bus_write_en stays 0, RAM unchanged.
- reset asserted during OWN1 with write_en high → next cycle gnt 00, bus_write_en 0, state IDLE.
